ptext_stream_buffer: RTL and testbench
======================================

Name: ptext_stream_buffer

Overview:
Parametrised plaintext message buffer. It sits between the plaintext loader (UART/switch front end) and the XOR cipher datapath. It accepts a message of up to 2**W words of B bits, commits it with an explicit last marker, then streams it to the cipher over a valid/ready handshake. Replay and continuous-loop modes are supported. Replaces the fixed, reset-preloaded plaintext ROM.

Parameters:
B, 8, data word width in bits
W, 4, address width; depth DEPTH = 2**W words

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous abort; discards message, returns to LOAD
wr_en  in  1  write strobe from loader
wr_data  in  B  word to store
wr_last  in  1  commit marker; may accompany wr_en or arrive alone
wr_full  out  1  buffer holds DEPTH words
wr_overflow  out  1  sticky; write attempted while full
start  in  1  begin streaming committed message
loop_mode  in  1  sampled on accepted start; 1 = wrap after last word indefinitely
out_data  out  B  word to cipher
out_valid  out  1  out_data valid
out_ready  in  1  cipher accepts word
out_last  out  1  out_data is final word of message (index len-1)
busy  out  1  state is STREAM
msg_len  out  W+1  committed length, 0..DEPTH

Behaviour:
- States: LOAD, READY, STREAM, DONE. On reset: state=LOAD; wr_ptr=0, count=0, msg_len=0, rd_ptr=0. All outputs 0: out_data, out_valid, out_last, wr_full, wr_overflow, busy. Memory contents are not reset and are undefined until written.
- clear: highest priority after reset. From any state it sets state=LOAD, count=0, msg_len=0, wr_overflow=0, out_valid=0, out_last=0. Memory is untouched.
- LOAD:
  - wr_en with count<DEPTH: mem[wr_ptr]<=wr_data; wr_ptr and count increment.
  - wr_en with count==DEPTH: word dropped; wr_overflow<=1.
  - wr_full = (count==DEPTH), combinational from count.
  - wr_last with an accepted wr_en: msg_len<=count+1; go to READY.
  - wr_last without an accepted write: if count>0, msg_len<=count and go to READY; if count==0, ignored and stay in LOAD.
  - start is ignored in LOAD.
- READY/DONE:
  - wr_en is ignored (no overflow flag).
  - start: latch loop_mode; rd_ptr<=1; out_data<=mem[0]; out_valid<=1; out_last<=(msg_len==1); go to STREAM.
  - Latency is 1 cycle: start high at edge N gives out_valid=1 after edge N.
- STREAM:
  - A transfer occurs when out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable. No combinational path from out_ready to out_valid.
  - On a transfer of a non-last word: out_data<=mem[rd_ptr]; out_last<=(rd_ptr==msg_len-1); rd_ptr increments. This gives back-to-back transfers with no bubble.
  - On a transfer of the last word with latched loop=1: out_data<=mem[0]; out_last<=(msg_len==1); rd_ptr<=1. out_valid stays 1.
  - On a transfer of the last word with loop=0: out_valid<=0, out_last<=0; go to DONE.
  - start is ignored during STREAM.
- rd_ptr/wr_ptr are W+1 bits wide. Index arithmetic uses the low W bits. With msg_len==DEPTH the final index is DEPTH-1 and no wrap occurs before the last marker.
- busy = (state==STREAM).
- Reset mid-stream: outputs drop to 0 asynchronously. The message is lost and must be reloaded.

Decomposition:
- Package ptext_pkg holds:
  - state encoding constants S_LOAD=2'd0, S_READY=2'd1, S_STREAM=2'd2, S_DONE=2'd3;
  - default B/W values.
- One sub-module, ptext_ram_dp: DEPTH x B storage with synchronous write and asynchronous read, no reset. The top holds the FSM, pointers and output register stage.

Test Plan:
- Load 0x31,0x32,0x33 with wr_last on the third word; start with loop_mode=0 and out_ready=1 → msg_len=3; out_data 0x31,0x32,0x33 on three consecutive cycles; out_last only on 0x33; then out_valid=0 and state DONE.
- Same message, out_ready toggles 1,0,0,1,1 → each word is held stable through the stall; exactly 3 transfers; no duplicate or skipped word.
- Write 17 words (W=4) → wr_full=1 after the 16th; 17th dropped and wr_overflow=1. wr_last alone → msg_len=16; streaming yields words 0..15 with out_last on index 15.
- loop_mode=1, 2-word message 0xAA,0x55, out_ready=1 for 7 cycles → 0xAA,0x55,0xAA,0x55,... with out_last on every 0x55. clear then drops out_valid next cycle; state LOAD, msg_len=0.
- From DONE, start again → identical replay of the stored message from index 0. wr_last with count==0 in LOAD → no state change.
- Assert reset mid-stream → out_valid, out_last, busy and msg_len go to 0 immediately without waiting for clk.

Source files
------------

// File: rtl/ptext_pkg.sv
// Shared definitions for the plaintext stream buffer: default sizes and FSM encoding.
package ptext_pkg;

  localparam int unsigned DEF_B = 8;
  localparam int unsigned DEF_W = 4;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_READY  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/ptext_ram_dp.sv
// DEPTH x B message storage: synchronous write, asynchronous read, contents not reset.
module ptext_ram_dp
  import ptext_pkg::*;
#(
  parameter int unsigned B = DEF_B,
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic [W-1:0] waddr,
  input  logic [B-1:0] wdata,
  input  logic [W-1:0] raddr,
  output logic [B-1:0] rdata
);

  logic [B-1:0] mem [2**W];

  // Single write port, clocked
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ptext_stream_buffer.sv
// Plaintext message buffer: loads a message, commits it on a last marker, then streams it
// out over valid/ready with optional replay and continuous looping.
module ptext_stream_buffer
  import ptext_pkg::*;
#(
  parameter int unsigned B = DEF_B,
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [B-1:0] wr_data,
  input  logic         wr_last,
  output logic         wr_full,
  output logic         wr_overflow,
  input  logic         start,
  input  logic         loop_mode,
  output logic [B-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic [W:0]   msg_len
);

  localparam int unsigned DEPTH     = 2**W;
  localparam logic [W:0]  DEPTH_CNT = (W+1)'(DEPTH);
  localparam logic [W:0]  ONE       = (W+1)'(1);

  state_e         state_q, state_d;
  logic [W:0]     wr_ptr_q, wr_ptr_d;
  logic [W:0]     count_q, count_d;
  logic [W:0]     msg_len_q, msg_len_d;
  logic [W:0]     rd_ptr_q, rd_ptr_d;
  logic           ovf_q, ovf_d;
  logic [B-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic           loop_q, loop_d;

  logic           wr_accept;
  logic           xfer;
  logic           mem_we;
  logic [W-1:0]   mem_raddr;
  logic [B-1:0]   mem_rdata;

  assign wr_full   = (count_q == DEPTH_CNT);
  assign wr_accept = wr_en && !wr_full;
  assign xfer      = valid_q && out_ready;
  assign mem_we    = (state_q == S_LOAD) && wr_accept && !clear;

  ptext_ram_dp #(
    .B(B),
    .W(W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[W-1:0]),
    .wdata (wr_data),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Read address: next word mid-pass, index 0 whenever a new pass is about to begin
  always_comb begin
    mem_raddr = '0;
    if (state_q == S_STREAM && !last_q) begin
      mem_raddr = rd_ptr_q[W-1:0];
    end
  end

  // Next-state and output-register logic; clear overrides everything
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    msg_len_d = msg_len_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    loop_d    = loop_q;

    if (clear) begin
      state_d   = S_LOAD;
      wr_ptr_d  = '0;
      count_d   = '0;
      msg_len_d = '0;
      ovf_d     = 1'b0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ONE;
            count_d  = count_q + ONE;
          end else if (wr_en) begin
            ovf_d = 1'b1;
          end
          if (wr_last) begin
            if (wr_accept) begin
              // wr_ptr equals count while loading
              msg_len_d = wr_ptr_q + ONE;
              state_d   = S_READY;
            end else if (count_q != '0) begin
              msg_len_d = count_q;
              state_d   = S_READY;
            end
          end
        end
        S_READY, S_DONE: begin
          if (start) begin
            loop_d   = loop_mode;
            rd_ptr_d = ONE;
            data_d   = mem_rdata;
            valid_d  = 1'b1;
            last_d   = (msg_len_q == ONE);
            state_d  = S_STREAM;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            if (!last_q) begin
              data_d   = mem_rdata;
              last_d   = (rd_ptr_q == msg_len_q - ONE);
              rd_ptr_d = rd_ptr_q + ONE;
            end else if (loop_q) begin
              data_d   = mem_rdata;
              last_d   = (msg_len_q == ONE);
              rd_ptr_d = ONE;
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // State and output registers, asynchronously reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_LOAD;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      msg_len_q <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      loop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      msg_len_q <= msg_len_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
    end
  end

  assign wr_overflow = ovf_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign busy        = (state_q == S_STREAM);
  assign msg_len     = msg_len_q;

endmodule

// File: tb/tb_ptext_stream_buffer.sv
// Self-checking bench for ptext_stream_buffer: directed scenarios plus random traffic,
// all compared every cycle against a message-level model.
module tb_ptext_stream_buffer;

  localparam int B     = 8;
  localparam int W     = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         wr_en;
  logic [B-1:0] wr_data;
  logic         wr_last;
  logic         wr_full;
  logic         wr_overflow;
  logic         start;
  logic         loop_mode;
  logic [B-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic [W:0]   msg_len;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ptext_stream_buffer #(
    .B(B),
    .W(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_full     (wr_full),
    .wr_overflow (wr_overflow),
    .start       (start),
    .loop_mode   (loop_mode),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .msg_len     (msg_len)
  );

  // Message-level model
  localparam int M_LOAD   = 0;
  localparam int M_READY  = 1;
  localparam int M_STREAM = 2;
  localparam int M_DONE   = 3;

  int m_state;
  int m_count;
  int m_len;
  int m_idx;
  bit m_ovf;
  bit m_valid;
  bit m_loop;
  int m_mem   [DEPTH];
  bit m_known [DEPTH];

  logic [B-1:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_LOAD;
    m_count = 0;
    m_len   = 0;
    m_idx   = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_loop  = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    if (clear) begin
      m_state = M_LOAD;
      m_count = 0;
      m_len   = 0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
    end else begin
      case (m_state)
        M_LOAD: begin
          acc = wr_en && (m_count < DEPTH);
          if (acc) begin
            m_mem[m_count]   = int'(wr_data);
            m_known[m_count] = 1'b1;
            m_count++;
          end else if (wr_en) begin
            m_ovf = 1'b1;
          end
          if (wr_last && m_count > 0) begin
            m_len   = m_count;
            m_state = M_READY;
          end
        end
        M_READY, M_DONE: begin
          if (start) begin
            m_loop  = loop_mode;
            m_idx   = 0;
            m_valid = 1'b1;
            m_state = M_STREAM;
          end
        end
        default: begin
          if (out_ready) begin
            if (m_idx == m_len - 1) begin
              if (m_loop) begin
                m_idx = 0;
              end else begin
                m_valid = 1'b0;
                m_state = M_DONE;
              end
            end else begin
              m_idx++;
            end
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_last", 32'(out_last), 32'(m_valid && (m_idx == m_len - 1)));
    chk("busy", 32'(busy), 32'(m_state == M_STREAM));
    chk("msg_len", 32'(msg_len), 32'(m_len));
    chk("wr_full", 32'(wr_full), 32'(m_count == DEPTH));
    chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    if (m_valid && m_known[m_idx]) begin
      chk("out_data", 32'(out_data), 32'(m_mem[m_idx]));
    end
  endtask

  // One clock: record a transfer, let model and DUT advance, compare, return at negedge
  task automatic cycle();
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_q.push_back(out_data);
    end
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    start     = 1'b0;
    loop_mode = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic write_word(input logic [B-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = last;
    cycle();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  initial begin
    logic [B-1:0] exp_w;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = 0;
      m_known[i] = 1'b0;
    end
    model_reset();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst msg_len", 32'(msg_len), 32'd0);
    chk("rst wr_full", 32'(wr_full), 32'd0);
    chk("rst wr_overflow", 32'(wr_overflow), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    reset = 1'b1;
    cycle();

    // Three-word message, straight stream
    write_word(8'h31, 1'b0);
    write_word(8'h32, 1'b0);
    write_word(8'h33, 1'b1);
    chk("t1 msg_len", 32'(msg_len), 32'd3);
    got_q.delete();
    start     = 1'b1;
    out_ready = 1'b1;
    cycle();
    start = 1'b0;
    chk("t1 first data", 32'(out_data), 32'h31);
    chk("t1 first last", 32'(out_last), 32'd0);
    cycle();
    cycle();
    chk("t1 last data", 32'(out_data), 32'h33);
    chk("t1 last flag", 32'(out_last), 32'd1);
    cycle();
    chk("t1 done valid", 32'(out_valid), 32'd0);
    chk("t1 transfers", 32'(got_q.size()), 32'd3);

    // Replay from DONE with stalls
    got_q.delete();
    start     = 1'b1;
    out_ready = 1'b0;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = (i == 0 || i >= 3);
      cycle();
    end
    chk("t2 transfers", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      exp_w = 8'h31 + 8'(i);
      chk("t2 word", 32'(got_q[i]), 32'(exp_w));
    end

    // Fill to capacity, overflow, commit with a bare last marker
    clear = 1'b1;
    cycle();
    clear     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write_word(8'h40 + 8'(i), 1'b0);
      if (i == 15) chk("t3 full", 32'(wr_full), 32'd1);
      if (i == 16) chk("t3 overflow", 32'(wr_overflow), 32'd1);
    end
    wr_last = 1'b1;
    cycle();
    wr_last = 1'b0;
    chk("t3 msg_len", 32'(msg_len), 32'd16);
    got_q.delete();
    start     = 1'b1;
    out_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (16) cycle();
    chk("t3 transfers", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      chk("t3 first word", 32'(got_q[0]), 32'h40);
      chk("t3 last word", 32'(got_q[15]), 32'h4f);
    end

    // Loop mode on a two-word message, then abort
    clear = 1'b1;
    cycle();
    clear     = 1'b0;
    out_ready = 1'b0;
    write_word(8'hAA, 1'b0);
    write_word(8'h55, 1'b1);
    got_q.delete();
    start     = 1'b1;
    loop_mode = 1'b1;
    out_ready = 1'b1;
    cycle();
    start     = 1'b0;
    loop_mode = 1'b0;
    repeat (7) cycle();
    chk("t4 transfers", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < got_q.size(); i++) begin
      exp_w = (i % 2 == 1) ? 8'h55 : 8'hAA;
      chk("t4 word", 32'(got_q[i]), 32'(exp_w));
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("t4 clear valid", 32'(out_valid), 32'd0);
    chk("t4 clear msg_len", 32'(msg_len), 32'd0);

    // Empty commit and start in LOAD are ignored
    out_ready = 1'b0;
    wr_last   = 1'b1;
    cycle();
    wr_last = 1'b0;
    start   = 1'b1;
    cycle();
    start = 1'b0;
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 msg_len", 32'(msg_len), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      clear     = ($urandom_range(0, 99) == 0);
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_data   = B'($urandom);
      wr_last   = ($urandom_range(0, 11) == 0);
      start     = ($urandom_range(0, 4) == 0);
      loop_mode = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    // Reset in the middle of a stream takes effect without a clock edge
    idle_inputs();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    write_word(8'h11, 1'b0);
    write_word(8'h22, 1'b0);
    write_word(8'h33, 1'b1);
    start     = 1'b1;
    loop_mode = 1'b1;
    out_ready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    chk("t6 streaming", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6 async valid", 32'(out_valid), 32'd0);
    chk("t6 async last", 32'(out_last), 32'd0);
    chk("t6 async busy", 32'(busy), 32'd0);
    chk("t6 async msg_len", 32'(msg_len), 32'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
